// File: rtl/regfile_write_ctrl.sv
// Register-file write-port controller: ALU/MDU arbitration onto one write port,
// an in-order MDU result buffer, and a pending-write scoreboard that drives the decode stall.
module regfile_write_ctrl #(
    parameter int FIFO_DEPTH = 2,
    parameter int NUM_REGS   = 32,
    parameter int XLEN       = 32,
    localparam int AW        = $clog2(NUM_REGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            mdu_issue,
    input  logic [AW-1:0]   mdu_issue_rd,
    input  logic            mdu_valid,
    output logic            mdu_ready,
    input  logic [AW-1:0]   mdu_rd,
    input  logic [XLEN-1:0] mdu_data,
    input  logic [AW-1:0]   dec_rs1,
    input  logic [AW-1:0]   dec_rs2,
    input  logic [AW-1:0]   dec_rd,
    output logic            hazard_stall,
    output logic            rf_we,
    output logic [AW-1:0]   rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            busy
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wr_req_t;

    wr_req_t             fifo_mem [FIFO_DEPTH];
    wr_req_t             head;
    logic [PW-1:0]       wr_ptr, rd_ptr;
    logic [CW-1:0]       count;
    logic [NUM_REGS-1:0] pending, pend_set, pend_clr;
    logic                push, pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // ALU has fixed priority; the buffered MDU head only drains on ALU-idle cycles.
    assign mdu_ready = (count < CW'(FIFO_DEPTH)) && !rst;
    assign push      = mdu_valid && mdu_ready;
    assign pop       = !alu_valid && (count != '0);
    assign head      = fifo_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= '{rd: mdu_rd, data: mdu_data};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Set is applied after clear so a re-issue in the pop cycle keeps the register pending.
    always_comb begin
        pend_set = '0;
        pend_clr = '0;
        if (mdu_issue && mdu_issue_rd != '0) pend_set[mdu_issue_rd] = 1'b1;
        if (pop && head.rd != '0)            pend_clr[head.rd]      = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pending <= '0;
        else     pending <= (pending & ~pend_clr) | pend_set;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (alu_valid) begin
            rf_we    <= (alu_rd != '0);
            rf_waddr <= alu_rd;
            rf_wdata <= alu_data;
        end else if (pop) begin
            rf_we    <= (head.rd != '0);
            rf_waddr <= head.rd;
            rf_wdata <= head.data;
        end else begin
            rf_we    <= 1'b0;
        end
    end

    assign hazard_stall = (pending[dec_rs1] && dec_rs1 != '0)
                       || (pending[dec_rs2] && dec_rs2 != '0)
                       || (pending[dec_rd]  && dec_rd  != '0);

    assign busy = (count != '0) || (|pending);

    // An MDU result must target a register that was issued (x0 results are discarded anyway).
    mdu_rd_pending: assert property (@(posedge clk) disable iff (rst)
        (push && mdu_rd != '0) |-> pending[mdu_rd]);

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// Scoreboard bench for regfile_write_ctrl: expected rf writes queued at stimulus time,
// popped by a negedge monitor; scenario tasks add cycle-exact inline checks.
module tb_regfile_write_ctrl;
    logic        clk, rst;
    logic        alu_valid, mdu_issue, mdu_valid, mdu_ready;
    logic [4:0]  alu_rd, mdu_issue_rd, mdu_rd, dec_rs1, dec_rs2, dec_rd, rf_waddr;
    logic [31:0] alu_data, mdu_data, rf_wdata;
    logic        hazard_stall, rf_we, busy;

    typedef struct { logic [4:0] a; logic [31:0] d; } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    regfile_write_ctrl #(.FIFO_DEPTH(2), .NUM_REGS(32), .XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .mdu_issue(mdu_issue), .mdu_issue_rd(mdu_issue_rd),
        .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
        .hazard_stall(hazard_stall),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached, required finish");
        $fatal(1, "timeout");
    end

    // Every rf write must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst && rf_we) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL rf_write: got x%0d=%h, required no write", rf_waddr, rf_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if (rf_waddr !== mon_e.a || rf_wdata !== mon_e.d) begin
                    bad++;
                    $display("FAIL rf_write: got x%0d=%h, required x%0d=%h",
                             rf_waddr, rf_wdata, mon_e.a, mon_e.d);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
        exp_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic idle_inputs();
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        mdu_issue = 0; mdu_issue_rd = 0;
        mdu_valid = 0; mdu_rd = 0; mdu_data = 0;
        dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;
    endtask

    task automatic drain(input string name);
        repeat (4) step();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: %0d writes outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_idle_busy: got %b, required 0", name, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (rf_we !== 1'b0)     begin bad++; $display("FAIL rst_we: got %b, required 0", rf_we); end
        total++; if (rf_waddr !== 5'd0)  begin bad++; $display("FAIL rst_waddr: got %0d, required 0", rf_waddr); end
        total++; if (rf_wdata !== 32'd0) begin bad++; $display("FAIL rst_wdata: got %h, required 0", rf_wdata); end
        total++; if (mdu_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b, required 0", mdu_ready); end
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL rst_busy: got %b, required 0", busy); end
        step(); rst = 0;
        @(negedge clk);
        total++; if (mdu_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready: got %b, required 1", mdu_ready); end

        // fill the buffer with two entries behind ALU traffic, then reset mid-run
        step(); mdu_issue = 1; mdu_issue_rd = 10;
        step(); mdu_issue_rd = 11;
        step(); mdu_issue = 0;
        alu_valid = 1; alu_rd = 1; alu_data = 32'h111; expect_wr(1, 32'h111);
        mdu_valid = 1; mdu_rd = 10; mdu_data = 32'hA10;
        step(); alu_rd = 0; alu_data = 32'hDEAD;
        mdu_rd = 11; mdu_data = 32'hA11;
        step();
        total++; if (mdu_ready !== 1'b0) begin bad++; $display("FAIL full_before_rst_ready: got %b, required 0", mdu_ready); end
        total++; if (busy !== 1'b1)      begin bad++; $display("FAIL full_before_rst_busy: got %b, required 1", busy); end
        idle_inputs();
        rst = 1;
        @(negedge clk);
        total++; if (rf_we !== 1'b0)     begin bad++; $display("FAIL midrst_we: got %b, required 0", rf_we); end
        total++; if (mdu_ready !== 1'b0) begin bad++; $display("FAIL midrst_ready: got %b, required 0", mdu_ready); end
        step(); rst = 0;
        @(negedge clk);
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL postrst_busy: got %b, required 0", busy); end
        total++; if (mdu_ready !== 1'b1) begin bad++; $display("FAIL postrst_ready: got %b, required 1", mdu_ready); end
        drain("reset");
    endtask

    task automatic test_alu();
        step(); alu_valid = 1; alu_rd = 5; alu_data = 32'h1234; expect_wr(5, 32'h1234);
        @(negedge clk);
        total++; if (hazard_stall !== 1'b0) begin bad++; $display("FAIL alu_stall: got %b, required 0", hazard_stall); end
        step(); alu_valid = 0;
        @(negedge clk);
        total++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h1234) begin
            bad++;
            $display("FAIL alu_latency: got we=%b x%0d=%h, required we=1 x5=00001234", rf_we, rf_waddr, rf_wdata);
        end
        step();
        @(negedge clk);
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL alu_idle_we: got %b, required 0", rf_we); end
        drain("alu");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            logic [4:0]  a;
            logic [31:0] d;
            a = 5'($urandom_range(1, 31));
            d = $urandom;
            step(); alu_valid = 1; alu_rd = a; alu_data = d; expect_wr(a, d);
        end
        step(); alu_valid = 0;
        drain("b2b");
    endtask

    task automatic test_collision();
        step(); mdu_issue = 1; mdu_issue_rd = 7;
        step(); mdu_issue = 0;
        alu_valid = 1; alu_rd = 3; alu_data = 32'h55;
        mdu_valid = 1; mdu_rd = 7; mdu_data = 32'hAA;
        expect_wr(3, 32'h55);
        expect_wr(7, 32'hAA);
        step(); alu_valid = 0; mdu_valid = 0;
        @(negedge clk);
        total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd3) begin bad++; $display("FAIL coll_first: got we=%b x%0d, required we=1 x3", rf_we, rf_waddr); end
        step();
        @(negedge clk);
        total++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'hAA) begin
            bad++;
            $display("FAIL coll_second: got we=%b x%0d=%h, required we=1 x7=000000aa", rf_we, rf_waddr, rf_wdata);
        end
        drain("collision");
    endtask

    task automatic test_fifo_full();
        logic [4:0]  rds [3];
        logic [31:0] dts [3];
        int          k;
        logic        rdy;
        rds = '{5'd12, 5'd13, 5'd14};
        dts = '{32'hC12, 32'hC13, 32'hC14};
        k = 0;
        for (int i = 0; i < 3; i++) begin
            step(); mdu_issue = 1; mdu_issue_rd = rds[i];
        end
        for (int c = 1; c <= 9; c++) begin
            step();
            mdu_issue = 0;
            alu_valid = (c <= 4);
            if (c <= 4) begin
                alu_rd = 5'(20 + c); alu_data = 32'(c * 256);
                expect_wr(alu_rd, alu_data);
            end
            if (c == 5)
                for (int j = 0; j < 3; j++) expect_wr(rds[j], dts[j]);
            mdu_valid = (k < 3);
            if (k < 3) begin mdu_rd = rds[k]; mdu_data = dts[k]; end
            @(negedge clk);
            rdy = mdu_ready;
            if (c == 3 || c == 5) begin
                total++; if (rdy !== 1'b0) begin bad++; $display("FAIL full_ready_c%0d: got %b, required 0", c, rdy); end
            end
            if (c == 6) begin
                total++; if (rdy !== 1'b1) begin bad++; $display("FAIL full_ready_c6: got %b, required 1", rdy); end
            end
            if (mdu_valid && rdy) k++;
        end
        total++; if (k != 3) begin bad++; $display("FAIL full_accepted: got %0d, required 3", k); end
        mdu_valid = 0;
        drain("fifo_full");
    endtask

    task automatic test_scoreboard();
        step(); mdu_issue = 1; mdu_issue_rd = 9; dec_rs1 = 0; dec_rs2 = 9; dec_rd = 0;
        @(negedge clk);
        total++; if (hazard_stall !== 1'b0) begin bad++; $display("FAIL sb_pre_issue: got %b, required 0", hazard_stall); end
        step(); mdu_issue = 0;
        @(negedge clk);
        total++; if (hazard_stall !== 1'b1) begin bad++; $display("FAIL sb_rs2: got %b, required 1", hazard_stall); end
        total++; if (busy !== 1'b1)         begin bad++; $display("FAIL sb_busy: got %b, required 1", busy); end
        step(); dec_rs2 = 0; dec_rd = 9;
        alu_valid = 1; alu_rd = 1; alu_data = 32'h1; expect_wr(1, 32'h1);
        mdu_valid = 1; mdu_rd = 9; mdu_data = 32'h99;
        @(negedge clk);
        total++; if (hazard_stall !== 1'b1) begin bad++; $display("FAIL sb_rd: got %b, required 1", hazard_stall); end
        step(); alu_valid = 0; mdu_valid = 0; dec_rd = 0; dec_rs1 = 9; expect_wr(9, 32'h99);
        @(negedge clk);
        total++; if (hazard_stall !== 1'b1) begin bad++; $display("FAIL sb_pop_cycle: got %b, required 1", hazard_stall); end
        step();
        @(negedge clk);
        total++; if (hazard_stall !== 1'b0) begin bad++; $display("FAIL sb_after_pop: got %b, required 0", hazard_stall); end
        total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd9) begin bad++; $display("FAIL sb_write: got we=%b x%0d, required we=1 x9", rf_we, rf_waddr); end
        step(); dec_rs1 = 0; mdu_issue = 1; mdu_issue_rd = 0;
        step(); mdu_issue = 0;
        @(negedge clk);
        total++; if (hazard_stall !== 1'b0) begin bad++; $display("FAIL sb_x0: got %b, required 0", hazard_stall); end
        drain("scoreboard");
    endtask

    task automatic test_x0();
        step(); alu_valid = 1; alu_rd = 4; alu_data = 32'h44; expect_wr(4, 32'h44);
        mdu_valid = 1; mdu_rd = 0; mdu_data = 32'h0F;
        step(); alu_valid = 0; mdu_valid = 0;
        @(negedge clk);
        total++; if (busy !== 1'b1)       begin bad++; $display("FAIL x0_buffered_busy: got %b, required 1", busy); end
        total++; if (rf_waddr !== 5'd4)   begin bad++; $display("FAIL x0_alu_write: got x%0d, required x4", rf_waddr); end
        step();
        @(negedge clk);
        total++; if (rf_we !== 1'b0)      begin bad++; $display("FAIL x0_we: got %b, required 0", rf_we); end
        total++; if (busy !== 1'b0)       begin bad++; $display("FAIL x0_popped: got busy=%b, required 0", busy); end

        // pop for x6 selected in the same cycle x6 is re-issued
        step(); mdu_issue = 1; mdu_issue_rd = 6;
        step(); mdu_issue = 0;
        alu_valid = 1; alu_rd = 2; alu_data = 32'h22; expect_wr(2, 32'h22);
        mdu_valid = 1; mdu_rd = 6; mdu_data = 32'h66;
        step(); alu_valid = 0; mdu_valid = 0; mdu_issue = 1; mdu_issue_rd = 6; expect_wr(6, 32'h66);
        step(); mdu_issue = 0; dec_rs1 = 6;
        @(negedge clk);
        total++; if (hazard_stall !== 1'b1) begin bad++; $display("FAIL setclr_stall: got %b, required 1", hazard_stall); end
        total++; if (busy !== 1'b1)         begin bad++; $display("FAIL setclr_busy: got %b, required 1", busy); end
        total++; if (rf_waddr !== 5'd6 || rf_we !== 1'b1) begin bad++; $display("FAIL setclr_write: got we=%b x%0d, required we=1 x6", rf_we, rf_waddr); end
        step(); mdu_valid = 1; mdu_rd = 6; mdu_data = 32'h67; expect_wr(6, 32'h67);
        step(); mdu_valid = 0;
        step(); step();
        @(negedge clk);
        total++; if (hazard_stall !== 1'b0) begin bad++; $display("FAIL setclr_cleared: got %b, required 0", hazard_stall); end
        dec_rs1 = 0;
        drain("x0");
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_alu();
        test_back_to_back();
        test_collision();
        test_fifo_full();
        test_scoreboard();
        test_x0();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
